// File: rtl/ddr3_pkg.sv
// Shared constants and helpers for the DDR3 narrow host port bridge.
package ddr3_pkg;

    // Burst size presented to the controller: every request is a single beat.
    localparam logic [6:0] AVL_SIZE_ONE = 7'h1;

    // log2 of a power-of-2 ratio; used to derive LB (lane bits) and OB (byte-offset bits).
    function automatic int lane_index(input int ratio);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < ratio) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/fifo.sv
// Small synchronous FIFO, show-ahead output; one extra pointer bit tells full from empty.
module fifo #(
    parameter int data_width = 1,
    parameter int depth_bits = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    logic [data_width-1:0] mem [2**depth_bits];
    logic [depth_bits:0]   wr_ptr;
    logic [depth_bits:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[depth_bits] != rd_ptr[depth_bits]) &&
                   (wr_ptr[depth_bits-1:0] == rd_ptr[depth_bits-1:0]);
    assign dout  = mem[rd_ptr[depth_bits-1:0]];

    // Pointer advance; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[depth_bits-1:0]] <= din;
    end

endmodule

// File: rtl/ddr3_narrow_port.sv
// Narrow single-beat host port to wide Avalon-MM DDR3 controller port.
// One-deep request register, lane steering, read credit tracking and lane-selected read return.
module ddr3_narrow_port
    import ddr3_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int AVL_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 27,
    parameter int TAG_DEPTH_BITS = 4,
    localparam int LB_P          = lane_index(AVL_DATA_WIDTH / DATA_WIDTH),
    localparam int OB_P          = lane_index(DATA_WIDTH / 8)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    output logic                               ready,
    input  logic [ADDR_WIDTH-1:0]              addr,
    input  logic [DATA_WIDTH-1:0]              write_data,
    input  logic [DATA_WIDTH/8-1:0]            byte_enable,
    input  logic                               write_req,
    input  logic                               read_req,
    output logic [DATA_WIDTH-1:0]              read_data,
    output logic                               read_data_valid,
    output logic                               rdata_underflow,
    input  logic                               avl_ready,
    output logic                               avl_burstbegin,
    output logic [ADDR_WIDTH-OB_P-LB_P-1:0]    avl_addr,
    input  logic                               avl_rdata_valid,
    input  logic [AVL_DATA_WIDTH-1:0]          avl_rdata,
    output logic [AVL_DATA_WIDTH-1:0]          avl_wdata,
    output logic [AVL_DATA_WIDTH/8-1:0]        avl_be,
    output logic                               avl_read_req,
    output logic                               avl_write_req,
    output logic [6:0]                         avl_size
);

    localparam int LB = LB_P;
    localparam int OB = OB_P;
    localparam int LW = (LB > 0) ? LB : 1;
    localparam int WA = ADDR_WIDTH - OB - LB;
    localparam logic [TAG_DEPTH_BITS:0] CREDIT_MAX = {1'b1, {TAG_DEPTH_BITS{1'b0}}};

    typedef struct packed {
        logic                    is_write;
        logic [WA-1:0]           waddr;
        logic [LW-1:0]           lane;
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] be;
    } pend_req_t;

    pend_req_t               pend;
    logic                    pend_valid;
    logic                    presented;
    logic [TAG_DEPTH_BITS:0] count;
    logic [LW-1:0]           req_lane;
    logic [LW-1:0]           fifo_lane;
    logic                    credit_full;
    logic                    acc_wr;
    logic                    acc_rd;
    logic                    rd_pop;
    logic                    unused_fifo_full;
    logic                    unused_fifo_empty;

    // Lane select from the host address; a single-lane build stores a dummy bit.
    if (LB > 0) begin : g_lane
        assign req_lane = addr[OB+LB-1:OB];
    end else begin : g_no_lane
        assign req_lane = 1'b0;
    end

    // Byte offset within a host word carries no information for the controller.
    if (OB > 0) begin : g_lsb
        logic unused_addr_lsb;
        assign unused_addr_lsb = ^addr[OB-1:0];
    end

    assign credit_full = (count == CREDIT_MAX);
    assign ready       = (!pend_valid || avl_ready) && !credit_full;
    assign acc_wr      = ready && write_req;
    assign acc_rd      = ready && read_req && !write_req;
    assign rd_pop      = avl_rdata_valid && (count != '0);

    assign avl_write_req  = pend_valid && pend.is_write;
    assign avl_read_req   = pend_valid && !pend.is_write;
    assign avl_burstbegin = pend_valid && !presented;
    assign avl_addr       = pend.waddr;
    assign avl_wdata      = AVL_DATA_WIDTH'(pend.data) << (32'(pend.lane) * DATA_WIDTH);
    assign avl_be         = (AVL_DATA_WIDTH/8)'(pend.be) << (32'(pend.lane) * (DATA_WIDTH/8));
    assign avl_size       = AVL_SIZE_ONE;

    // Pending request register: loaded on accept, held until the controller takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend       <= '0;
            presented  <= 1'b0;
        end else begin
            if (pend_valid && avl_ready) pend_valid <= 1'b0;
            if (acc_wr || acc_rd) begin
                pend_valid <= 1'b1;
                pend <= '{is_write: acc_wr, waddr: addr[ADDR_WIDTH-1:OB+LB],
                          lane: req_lane, data: write_data, be: byte_enable};
            end
            if (pend_valid && !avl_ready) presented <= 1'b1;
            else if (pend_valid)          presented <= 1'b0;
        end
    end

    // Read credits count accepted-but-unreturned reads; a return with no credit is an error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count           <= '0;
            rdata_underflow <= 1'b0;
        end else begin
            if (acc_rd && !rd_pop)      count <= count + 1'b1;
            else if (!acc_rd && rd_pop) count <= count - 1'b1;
            if (avl_rdata_valid && (count == '0)) rdata_underflow <= 1'b1;
        end
    end

    // Read return: select the lane recorded at request time, one cycle after the controller returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_valid <= 1'b0;
            read_data       <= '0;
        end else begin
            read_data_valid <= rd_pop;
            if (rd_pop) read_data <= DATA_WIDTH'(avl_rdata >> (32'(fifo_lane) * DATA_WIDTH));
        end
    end

    fifo #(
        .data_width (LW),
        .depth_bits (TAG_DEPTH_BITS)
    ) u_lane_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (acc_rd),
        .pop   (rd_pop),
        .din   (req_lane),
        .dout  (fifo_lane),
        .full  (unused_fifo_full),
        .empty (unused_fifo_empty)
    );

endmodule

// File: tb/tb_ddr3_narrow_port.sv
// Bench for ddr3_narrow_port: directed vector tables, multi-cycle corner sequences,
// a 128-bit-wide instance for lane 3, and randomized traffic against a transaction model.
module tb_ddr3_narrow_port;

    logic        clk;
    logic        reset_n;

    // default instance (32 -> 64)
    logic        ready, write_req, read_req, read_data_valid, rdata_underflow;
    logic [26:0] addr;
    logic [31:0] write_data, read_data;
    logic [3:0]  byte_enable;
    logic        avl_ready, avl_burstbegin, avl_rdata_valid, avl_read_req, avl_write_req;
    logic [23:0] avl_addr;
    logic [63:0] avl_rdata, avl_wdata;
    logic [7:0]  avl_be;
    logic [6:0]  avl_size;

    // wide instance (32 -> 128)
    logic         b_ready, b_write_req, b_read_req, b_read_data_valid, b_rdata_underflow;
    logic [26:0]  b_addr;
    logic [31:0]  b_write_data, b_read_data;
    logic [3:0]   b_byte_enable;
    logic         b_avl_ready, b_avl_burstbegin, b_avl_rdata_valid, b_avl_read_req, b_avl_write_req;
    logic [22:0]  b_avl_addr;
    logic [127:0] b_avl_rdata, b_avl_wdata;
    logic [15:0]  b_avl_be;
    logic [6:0]   b_avl_size;

    int checks = 0;
    int errors = 0;

    ddr3_narrow_port dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .addr(addr), .write_data(write_data),
        .byte_enable(byte_enable), .write_req(write_req), .read_req(read_req),
        .read_data(read_data), .read_data_valid(read_data_valid), .rdata_underflow(rdata_underflow),
        .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr),
        .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata), .avl_wdata(avl_wdata),
        .avl_be(avl_be), .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
        .avl_size(avl_size)
    );

    ddr3_narrow_port #(.AVL_DATA_WIDTH(128)) dut_wide (
        .clk(clk), .reset_n(reset_n), .ready(b_ready), .addr(b_addr), .write_data(b_write_data),
        .byte_enable(b_byte_enable), .write_req(b_write_req), .read_req(b_read_req),
        .read_data(b_read_data), .read_data_valid(b_read_data_valid),
        .rdata_underflow(b_rdata_underflow), .avl_ready(b_avl_ready),
        .avl_burstbegin(b_avl_burstbegin), .avl_addr(b_avl_addr),
        .avl_rdata_valid(b_avl_rdata_valid), .avl_rdata(b_avl_rdata), .avl_wdata(b_avl_wdata),
        .avl_be(b_avl_be), .avl_read_req(b_avl_read_req), .avl_write_req(b_avl_write_req),
        .avl_size(b_avl_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both requests high at once: the write wins and the read is silently dropped.
    always @(posedge clk)
        if (reset_n) assert (!(write_req && read_req))
            else $warning("write_req and read_req both high: read dropped");

    typedef struct {
        logic [26:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [23:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_be;
    } wr_vec_t;

    typedef struct {
        logic [26:0] addr;
        logic [63:0] rdata;
        logic [23:0] exp_addr;
        logic [31:0] exp_data;
    } rd_vec_t;

    wr_vec_t wv[5];
    rd_vec_t rv[3];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_req = 0; read_req = 0; addr = '0; write_data = '0; byte_enable = '0;
        avl_ready = 1; avl_rdata_valid = 0; avl_rdata = '0;
        b_write_req = 0; b_read_req = 0; b_addr = '0; b_write_data = '0; b_byte_enable = '0;
        b_avl_ready = 1; b_avl_rdata_valid = 0; b_avl_rdata = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle();
        #7;
        reset_n = 1;
        step();
    endtask

    // transaction model state for the random phase
    bit          m_pv, m_first, m_isw, m_rdv;
    logic [23:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_be;
    logic [31:0] m_rd;
    int          lane_q[$];
    bit          t_wr, t_rd, t_rv, exp_ready;

    initial begin
        logic [63:0] r5 [5];
        int          lanes5 [5];
        int          ln;

        wv[0] = '{27'h0000004, 32'hDEADBEEF, 4'hF, 24'h000000, 64'hDEADBEEF_00000000, 8'hF0};
        wv[1] = '{27'h0000000, 32'h12345678, 4'h3, 24'h000000, 64'h00000000_12345678, 8'h03};
        wv[2] = '{27'h0001008, 32'hA5A5A5A5, 4'hC, 24'h000201, 64'h00000000_A5A5A5A5, 8'h0C};
        wv[3] = '{27'h7FFFFFF, 32'hCAFEF00D, 4'h9, 24'hFFFFFF, 64'hCAFEF00D_00000000, 8'h90};
        wv[4] = '{27'h000000F, 32'h01020304, 4'h1, 24'h000001, 64'h01020304_00000000, 8'h10};
        rv[0] = '{27'h000000C, 64'h11112222_33334444, 24'h000001, 32'h11112222};
        rv[1] = '{27'h0000008, 64'h11112222_33334444, 24'h000001, 32'h33334444};
        rv[2] = '{27'h0000010, 64'hAAAA5555_0F0F0F0F, 24'h000002, 32'h0F0F0F0F};

        // reset state
        reset_n = 0;
        idle();
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_avl_size", avl_size, 7'h1);
        chk("rst_outputs", {avl_write_req, avl_read_req, avl_burstbegin, read_data_valid,
                            rdata_underflow}, 0);
        chk("rst_buses", {avl_addr, avl_wdata, avl_be, read_data}, 0);
        reset_n = 1;
        step();

        // write steering table
        for (int i = 0; i < 5; i++) begin
            write_req = 1; addr = wv[i].addr; write_data = wv[i].wd; byte_enable = wv[i].be;
            step();
            write_req = 0;
            chk("wr_req", avl_write_req, 1);
            chk("wr_bb", avl_burstbegin, 1);
            chk("wr_addr", avl_addr, wv[i].exp_addr);
            chk("wr_wdata", avl_wdata, wv[i].exp_wdata);
            chk("wr_be", avl_be, wv[i].exp_be);
            step();
            chk("wr_taken", avl_write_req, 0);
        end

        // read return table
        for (int i = 0; i < 3; i++) begin
            read_req = 1; addr = rv[i].addr;
            step();
            read_req = 0;
            chk("rd_req", avl_read_req, 1);
            chk("rd_addr", avl_addr, rv[i].exp_addr);
            avl_rdata_valid = 1; avl_rdata = rv[i].rdata;
            step();
            avl_rdata_valid = 0;
            chk("rd_valid", read_data_valid, 1);
            chk("rd_data", read_data, rv[i].exp_data);
            step();
            chk("rd_valid_drop", read_data_valid, 0);
        end

        // stall: avl_ready low for three presented cycles
        write_req = 1; addr = 27'h4; write_data = 32'h55AA55AA; byte_enable = 4'h3; avl_ready = 0;
        #1;
        chk("stall_ready_empty", ready, 1);
        step();
        write_req = 0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_bb", avl_burstbegin, (k == 0) ? 1 : 0);
            chk("stall_req", avl_write_req, 1);
            chk("stall_wdata", avl_wdata, 64'h55AA55AA_00000000);
            chk("stall_be", avl_be, 8'h30);
            chk("stall_ready", ready, 0);
            if (k < 2) step();
        end
        avl_ready = 1;
        #1;
        chk("stall_ready_release", ready, 1);
        step();
        chk("stall_taken", avl_write_req, 0);
        chk("stall_bb_off", avl_burstbegin, 0);

        // credit exhaustion with 16 outstanding reads
        do_reset();
        for (int i = 0; i < 16; i++) begin
            read_req = 1; addr = 27'(i * 4);
            #1;
            chk("credit_ready", ready, 1);
            step();
        end
        chk("credit_full_ready", ready, 0);
        step();
        chk("credit_17th_stalled", avl_read_req, 0);
        read_req = 0; avl_rdata_valid = 1; avl_rdata = 64'h01234567_89ABCDEF;
        step();
        avl_rdata_valid = 0;
        chk("credit_ret_valid", read_data_valid, 1);
        chk("credit_ret_data", read_data, 32'h89ABCDEF);
        chk("credit_restored", ready, 1);

        // accept coincident with return at count 5; lane order 0,1,1,0,1 then 0
        do_reset();
        lanes5 = '{0, 1, 1, 0, 1};
        for (int i = 0; i < 5; i++) begin
            read_req = 1; addr = 27'(i * 8 + lanes5[i] * 4);
            step();
        end
        read_req = 1; addr = 27'h100; avl_rdata_valid = 1; avl_rdata = 64'hA0000000_50000000;
        step();
        read_req = 0; avl_rdata_valid = 0;
        chk("coinc_valid", read_data_valid, 1);
        chk("coinc_data", read_data, 32'h50000000);
        for (int i = 0; i < 11; i++) begin
            read_req = 1; addr = 27'h200;
            #1;
            chk("coinc_fill_ready", ready, 1);
            step();
        end
        read_req = 0;
        #1;
        chk("coinc_count_16", ready, 0);
        lanes5 = '{1, 1, 0, 1, 0};
        for (int j = 0; j < 5; j++) begin
            r5[j] = {32'hA0000000 + 32'(j + 1), 32'h50000000 + 32'(j + 1)};
            avl_rdata_valid = 1; avl_rdata = r5[j];
            step();
            chk("order_valid", read_data_valid, 1);
            chk("order_data", read_data, lanes5[j] ? r5[j][63:32] : r5[j][31:0]);
        end
        avl_rdata_valid = 0;

        // underflow after reset, both widths
        do_reset();
        avl_rdata_valid = 1; b_avl_rdata_valid = 1;
        step();
        avl_rdata_valid = 0; b_avl_rdata_valid = 0;
        chk("uf_set", rdata_underflow, 1);
        chk("uf_no_valid", read_data_valid, 0);
        chk("uf_wide_set", b_rdata_underflow, 1);
        step(); step(); step();
        chk("uf_sticky", rdata_underflow, 1);
        chk("uf_no_valid_later", read_data_valid, 0);

        // 128-bit controller: lane 3 via addr[3:2]
        do_reset();
        chk("uf_cleared", rdata_underflow, 0);
        b_read_req = 1; b_addr = 27'hC;
        step();
        b_read_req = 0;
        chk("wide_rd_req", b_avl_read_req, 1);
        chk("wide_rd_addr", b_avl_addr, 0);
        b_avl_rdata_valid = 1; b_avl_rdata = 128'h44444444_33333333_22222222_11111111;
        step();
        b_avl_rdata_valid = 0;
        chk("wide_rd_valid", b_read_data_valid, 1);
        chk("wide_rd_lane3", b_read_data, 32'h44444444);
        b_write_req = 1; b_addr = 27'h1C; b_write_data = 32'h12345678; b_byte_enable = 4'hF;
        step();
        b_write_req = 0;
        chk("wide_wr_addr", b_avl_addr, 23'h1);
        chk("wide_wr_be", b_avl_be, 16'hF000);
        chk("wide_wr_wdata", b_avl_wdata, {32'h12345678, 96'h0});

        // randomized traffic against the transaction model
        do_reset();
        m_pv = 0; m_first = 0; m_isw = 0; m_rdv = 0;
        m_addr = '0; m_wdata = '0; m_be = '0; m_rd = '0;
        lane_q.delete();
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 9));
            t_wr = (r < 3);
            t_rd = (r >= 3 && r < 6);
            write_req = t_wr; read_req = t_rd;
            addr = 27'($urandom); write_data = $urandom; byte_enable = 4'($urandom);
            avl_ready = ($urandom_range(0, 9) < 7);
            t_rv = (lane_q.size() > 0) && ($urandom_range(0, 2) == 0);
            avl_rdata_valid = t_rv;
            avl_rdata = {$urandom, $urandom};
            #1;
            exp_ready = (!m_pv || avl_ready) && (lane_q.size() < 16);
            chk("rnd_ready", ready, exp_ready);
            chk("rnd_wr_req", avl_write_req, m_pv && m_isw);
            chk("rnd_rd_req", avl_read_req, m_pv && !m_isw);
            chk("rnd_bb", avl_burstbegin, m_pv && m_first);
            if (m_pv) chk("rnd_addr", avl_addr, m_addr);
            if (m_pv && m_isw) begin
                chk("rnd_wdata", avl_wdata, m_wdata);
                chk("rnd_be", avl_be, m_be);
            end
            chk("rnd_rdv", read_data_valid, m_rdv);
            if (m_rdv) chk("rnd_rdata", read_data, m_rd);
            chk("rnd_underflow", rdata_underflow, 0);
            @(posedge clk);
            if (m_pv) begin
                if (avl_ready) m_pv = 0;
                else m_first = 0;
            end
            m_rdv = 0;
            if (t_rv) begin
                ln = lane_q.pop_front();
                m_rdv = 1;
                m_rd = (ln != 0) ? avl_rdata[63:32] : avl_rdata[31:0];
            end
            if (exp_ready && (t_wr || t_rd)) begin
                m_pv = 1; m_first = 1; m_isw = t_wr;
                m_addr = addr[26:3];
                m_wdata = addr[2] ? {write_data, 32'h0} : {32'h0, write_data};
                m_be = addr[2] ? {byte_enable, 4'h0} : {4'h0, byte_enable};
                if (!t_wr) lane_q.push_back(int'(addr[2]));
            end
            #1;
        end

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
